// File: rtl/uart_pkg.sv
// Shared state encoding, default parameters and helpers for the UART transmit arbiter.
package uart_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_BUSY_TIMEOUT = 4;
    localparam int DEF_LOCK_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        HOLD      = 2'd3
    } arb_state_t;

    // One-hot (up to 8 requesters) to binary index.
    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: one-hot of the first set request at or after ptr, wrapping.
module uart_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         pick
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] dbl_pick;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   rot_pick;

    // Rotate right so ptr sits at bit 0, take the lowest set bit, rotate back.
    assign dbl      = {req, req} >> ptr;
    assign rot      = dbl[NUM_REQ-1:0];
    assign rot_pick = rot & (~rot + NUM_REQ'(1));
    assign dbl_pick = {rot_pick, rot_pick} << ptr;
    assign pick     = dbl_pick[2*NUM_REQ-1:NUM_REQ];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from NUM_REQ byte requesters.
// Define UART_ARB_LOCK_EN to keep the grant for a whole frame (req_last-delimited).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int BW    = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t         state, state_d;
    logic [NUM_REQ-1:0] grant_d, ack_d;
    logic               tx_start_d, err_d, last_q, last_d;
    logic [7:0]         tx_data_d;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_d, owner, owner_d, issue_idx;
    logic [BW-1:0]      busy_cnt, busy_cnt_d;
    logic [NUM_REQ-1:0] pick, issue_oh;
    logic               issue, post, rel;

`ifdef UART_ARB_LOCK_EN
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    logic [LW-1:0] idle_cnt, idle_cnt_d;
`else
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .pick (pick)
    );

    // While holding a frame only the current owner may be issued.
    assign issue_oh  = (state == HOLD) ? grant : pick;
    assign issue_idx = PTR_W'(oh_to_idx(8'(issue_oh)));

    always_comb begin
        state_d    = state;
        grant_d    = grant;
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data;
        err_d      = err;
        rr_ptr_d   = rr_ptr;
        owner_d    = owner;
        busy_cnt_d = busy_cnt;
        last_d     = last_q;
        issue      = 1'b0;
        post       = 1'b0;
        rel        = 1'b0;
`ifdef UART_ARB_LOCK_EN
        idle_cnt_d = idle_cnt;
`endif
        case (state)
            IDLE: issue = !tx_busy && (|req);
            WAIT_BUSY: begin
                if (tx_busy)
                    state_d = WAIT_DONE;
                else if (busy_cnt >= BW'(BUSY_TIMEOUT - 1)) begin
                    err_d = 1'b1;
                    post  = 1'b1;
                end else
                    busy_cnt_d = busy_cnt + BW'(1);
            end
            WAIT_DONE: post = !tx_busy;
`ifdef UART_ARB_LOCK_EN
            HOLD: begin
                if (req[owner]) begin
                    if (!tx_busy) begin
                        issue      = 1'b1;
                        idle_cnt_d = '0;
                    end
                end else if (idle_cnt >= LW'(LOCK_TIMEOUT - 1))
                    rel = 1'b1;
                else
                    idle_cnt_d = idle_cnt + LW'(1);
            end
`endif
            default: state_d = IDLE;
        endcase

        if (issue) begin
            state_d    = WAIT_BUSY;
            grant_d    = issue_oh;
            ack_d      = issue_oh;
            tx_start_d = 1'b1;
            tx_data_d  = req_data[{issue_idx, 3'b000} +: 8];
            owner_d    = issue_idx;
            busy_cnt_d = '0;
`ifdef UART_ARB_LOCK_EN
            last_d     = req_last[issue_idx];
`else
            last_d     = 1'b1;
`endif
        end

        if (post) begin
`ifdef UART_ARB_LOCK_EN
            if (last_q) rel = 1'b1;
            else        state_d = HOLD;
`else
            rel = 1'b1;
`endif
        end

        if (rel) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
`ifdef UART_ARB_LOCK_EN
            idle_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            err      <= 1'b0;
            rr_ptr   <= '0;
            owner    <= '0;
            busy_cnt <= '0;
            last_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            idle_cnt <= '0;
`endif
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            ack      <= ack_d;
            tx_start <= tx_start_d;
            tx_data  <= tx_data_d;
            err      <= err_d;
            rr_ptr   <= rr_ptr_d;
            owner    <= owner_d;
            busy_cnt <= busy_cnt_d;
            last_q   <= last_d;
`ifdef UART_ARB_LOCK_EN
            idle_cnt <= idle_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; frame-lock sequences run when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, req_last, ack, grant;
    logic [8*N-1:0] req_data;
    logic           tx_start, tx_busy, err;
    logic [7:0]     tx_data;
    int             total = 0;
    int             bad = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(4), .LOCK_TIMEOUT(1023)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .grant    (grant),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        int           busy_len;   // 0: transmitter never goes busy
        logic [N-1:0] exp_grant;
        logic [7:0]   exp_data;
        logic         exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (ack == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (ack == '0) begin
            bad++;
            $display("FAIL %s: no ack within 20 cycles", name);
        end
    endtask

    // Called on the negedge where ack/tx_start are visible; transmitter rises one cycle later.
    task automatic busy_cycle(input int len);
        @(negedge clk);
        check("ack_one_cycle", 32'(ack), 0);
        check("start_one_cycle", 32'(tx_start), 0);
        tx_busy = 1'b1;
        repeat (len) @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        req     = '0;
        tx_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_issue(input string name, input logic [N-1:0] g, input logic [7:0] d);
        check({name, "_grant"}, 32'(grant), 32'(g));
        check({name, "_ack"}, 32'(ack), 32'(g));
        check({name, "_start"}, 32'(tx_start), 1);
        check({name, "_data"}, 32'(tx_data), 32'(d));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] nb;
        vecs[0] = '{4'b0011, 10, 4'b0001, 8'hA0, 1'b0};
        vecs[1] = '{4'b0011, 10, 4'b0010, 8'hB1, 1'b0};
        vecs[2] = '{4'b0001,  2, 4'b0001, 8'hA0, 1'b0};
        vecs[3] = '{4'b1100,  3, 4'b0100, 8'hC2, 1'b0};
        vecs[4] = '{4'b1001,  1, 4'b1000, 8'hD3, 1'b0};
        vecs[5] = '{4'b1010,  2, 4'b0010, 8'hB1, 1'b0};
        vecs[6] = '{4'b0010,  0, 4'b0010, 8'hB1, 1'b1};
        vecs[7] = '{4'b0001,  2, 4'b0001, 8'hA0, 1'b1};

        reset    = 1'b1;
        req      = '0;
        req_last = '1;
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        tx_busy  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_start", 32'(tx_start), 0);
        check("rst_data", 32'(tx_data), 0);
        check("rst_err", 32'(err), 0);
        reset = 1'b0;

        // Round-robin walk from pointer 0, including wrap and a busy timeout.
        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            wait_ack($sformatf("v%0d_ack", i));
            check_issue($sformatf("v%0d", i), vecs[i].exp_grant, vecs[i].exp_data);
            req = '0;
            if (vecs[i].busy_len == 0) begin
                repeat (3) @(negedge clk);
                check($sformatf("v%0d_err_early", i), 32'(err), 0);
                check($sformatf("v%0d_grant_early", i), 32'(grant), 32'(vecs[i].exp_grant));
                @(negedge clk);
            end else
                busy_cycle(vecs[i].busy_len);
            check($sformatf("v%0d_release", i), 32'(grant), 0);
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
        end

        // Reset while the transmitter is busy (WAIT_DONE); pointer is 1 beforehand.
        req = 4'b0001;
        wait_ack("rmid_ack");
        check_issue("rmid", 4'b0001, 8'hA0);
        req = '0;
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rmid_grant", 32'(grant), 0);
        check("rmid_ack0", 32'(ack), 0);
        check("rmid_start0", 32'(tx_start), 0);
        check("rmid_data0", 32'(tx_data), 0);
        check("rmid_err0", 32'(err), 0);
        req = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rmid_busy_hold", 32'(tx_start), 0);
        end
        tx_busy = 1'b0;
        wait_ack("rmid_after_ack");
        check_issue("rmid_after", 4'b0001, 8'hA0);
        req = '0;
        busy_cycle(2);
        check("rmid_after_rel", 32'(grant), 0);

        // Continuous requests from all: one byte each, rotating 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack($sformatf("rot%0d_ack", k));
            check($sformatf("rot%0d_grant", k), 32'(grant), 32'(1 << (k % 4)));
            busy_cycle(2);
        end
        req = '0;

`ifdef UART_ARB_LOCK_EN
        // Three-byte frame from req0 while req1 waits.
        do_reset();
        req_last = '0;
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA1};
        req      = 4'b0011;
        for (int b = 0; b < 3; b++) begin
            wait_ack($sformatf("lock%0d_ack", b));
            nb = 8'hA1 + 8'(b);
            check_issue($sformatf("lock%0d", b), 4'b0001, nb);
            if (b < 2) begin
                req_data[7:0] = nb + 8'h01;
                req_last[0]   = (b == 1);
            end else begin
                req      = 4'b0010;
                req_last = '1;
            end
            busy_cycle(2);
            check($sformatf("lock%0d_hold", b), 32'(grant), (b < 2) ? 1 : 0);
        end
        wait_ack("lock_next_ack");
        check_issue("lock_next", 4'b0010, 8'hB1);
        req = '0;
        busy_cycle(2);

        // Non-last byte then silence: grant held for the idle timeout.
        do_reset();
        req_last = '0;
        req      = 4'b0100;
        wait_ack("idle_ack");
        check_issue("idle", 4'b0100, 8'hC2);
        req = '0;
        busy_cycle(2);
        check("idle_hold0", 32'(grant), 32'(4'b0100));
        repeat (1022) @(negedge clk);
        check("idle_hold_end", 32'(grant), 32'(4'b0100));
        @(negedge clk);
        check("idle_release", 32'(grant), 0);
        req_last = '1;
        req      = 4'b1001;
        wait_ack("idle_ptr_ack");
        check_issue("idle_ptr", 4'b1000, 8'hD3);
        req = '0;
        busy_cycle(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
